// File: rtl/score_vector_collector.sv
// ============================================================================
// score_vector_collector: serial score beats -> parallel vector for argmax.
// Optional: SCORE_VECTOR_COLLECTOR_RELU_EN clamps negative scores at capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_vector_collector #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data [0:N_OUT-1],
  output logic                     enable,
  input  logic                     layer_done,
  output logic                     frame_err,
  output logic [7:0]               vec_count
);

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    REARM   = 2'd2
  } state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       ready_q;
  logic                       enable_q;
  logic                       frame_err_q;
  logic [7:0]                 vec_count_q;
  logic signed [DATA_W-1:0]   data_q [0:N_OUT-1];
  logic signed [DATA_W-1:0]   beat_d;
  logic                       accept_d;

  always_comb begin
`ifdef SCORE_VECTOR_COLLECTOR_RELU_EN
    beat_d = in_data[DATA_W-1] ? '0 : in_data;
`else
    beat_d = in_data;
`endif
  end

  assign accept_d = in_valid && ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      enable_q    <= 1'b0;
      frame_err_q <= 1'b0;
      vec_count_q <= '0;
      for (int i = 0; i < N_OUT; i++) data_q[i] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_d) begin
            data_q[idx_q] <= beat_d;
            // Completion takes priority over an early in_last on the same beat.
            if (idx_q == LAST_IDX) begin
              state_q     <= PRESENT;
              idx_q       <= '0;
              ready_q     <= 1'b0;
              enable_q    <= 1'b1;
              vec_count_q <= vec_count_q + 8'd1;
              if (!in_last) frame_err_q <= 1'b1;
            end else if (in_last) begin
              idx_q       <= '0;
              frame_err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (layer_done) begin
            state_q  <= REARM;
            enable_q <= 1'b0;
          end
        end
        REARM: begin
          // Wait for done to drop so a held done cannot retire the next vector.
          if (!layer_done) begin
            state_q <= FILL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= FILL;
          idx_q    <= '0;
          ready_q  <= 1'b1;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q & reset;
  assign enable    = enable_q;
  assign frame_err = frame_err_q;
  assign vec_count = vec_count_q;
  assign out_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_score_vector_collector.sv
// Directed bench for score_vector_collector with a vector scoreboard.
`default_nettype none

module tb_score_vector_collector;

  localparam int N = 10;
  localparam int W = 16;

  typedef logic [N-1:0][W-1:0] pvec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic                in_last = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] out_data [0:N-1];
  logic                enable;
  logic                layer_done = 1'b0;
  logic                frame_err;
  logic [7:0]          vec_count;

  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    fail_cnt = 0;
  pvec_t sb[$];

  score_vector_collector #(.N_OUT(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .enable(enable), .layer_done(layer_done), .frame_err(frame_err),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [W-1:0] model_capture(input logic signed [W-1:0] d);
`ifdef SCORE_VECTOR_COLLECTOR_RELU_EN
    return (d < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic send_beat(input logic signed [W-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends nb beats; in_last asserted on beat index last_at (-1 = never).
  // A full N-beat vector pushes its expected captured contents.
  task automatic send_vec(input pvec_t v, input int nb, input int last_at);
    pvec_t e;
    for (int i = 0; i < N; i++) e[i] = model_capture(v[i]);
    if (nb == N) sb.push_back(e);
    for (int i = 0; i < nb; i++) send_beat(v[i], (i == last_at));
  endtask

  // Called right after the final beat: enable must already be up.
  task automatic expect_present(input string tag);
    pvec_t e;
    chk({tag, "_enable"}, enable, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < N; i++)
        chk($sformatf("%s_data%0d", tag, i), out_data[i], $signed(e[i]));
    end
  endtask

  task automatic retire(input string tag);
    layer_done = 1'b1;
    tick();
    chk({tag, "_enable_drop"}, enable, 0);
    chk({tag, "_rearm_ready"}, in_ready, 0);
    layer_done = 1'b0;
    tick();
    chk({tag, "_fill_ready"}, in_ready, 1);
  endtask

  pvec_t va, vb, vc, vp;

  initial begin
    va = '0; va[2] = 16'd5; va[3] = 16'd85; va[5] = 16'd10;
    for (int i = 0; i < N; i++) vb[i] = W'(100 + i);
    vb[2] = -16'sd20;
    for (int i = 0; i < N; i++) vc[i] = W'(i * 3 - 7);
    vp = '0; vp[0] = 16'd1; vp[1] = 16'd2; vp[2] = 16'd3; vp[3] = 16'd4;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_enable", enable, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_vec_count", vec_count, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Nominal vector
    send_vec(va, N, N - 1);
    expect_present("vecA");
    chk("vecA_count", vec_count, 1);
    chk("vecA_ferr", frame_err, 0);

    // Beats offered during PRESENT are not consumed
    in_valid = 1'b1;
    in_data  = 16'sd777;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold_ready%0d", c), in_ready, 0);
      chk($sformatf("hold_enable%0d", c), enable, 1);
    end
    in_valid = 1'b0;
    chk("hold_d3", out_data[3], 85);
    chk("hold_d0", out_data[0], 0);

    // layer_done held 3 cycles: REARM until it drops
    layer_done = 1'b1;
    tick();
    chk("done3_enable", enable, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("done3_rearm%0d", c), in_ready, 0);
    end
    layer_done = 1'b0;
    tick();
    chk("done3_fill", in_ready, 1);
    chk("done3_count", vec_count, 1);

    // Early in_last: error, no presentation
    send_vec(vp, 4, 3);
    chk("short_ferr", frame_err, 1);
    chk("short_enable", enable, 0);
    chk("short_ready", in_ready, 1);
    tick();
    chk("short_enable2", enable, 0);

    // Full vector after the short one; includes -20 at index 2
    send_vec(vb, N, N - 1);
    expect_present("vecB");
    chk("vecB_count", vec_count, 2);
    chk("vecB_ferr", frame_err, 1);
    retire("vecB");

    // Reset mid-vector
    send_vec(vc, 6, -1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_enable", enable, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_count", vec_count, 0);
    for (int i = 0; i < N; i++) chk($sformatf("mid_rst_d%0d", i), out_data[i], 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rel_ready", in_ready, 1);

    // Full vector without in_last: presented, frame error flagged
    send_vec(vc, N, -1);
    expect_present("vecC");
    chk("vecC_count", vec_count, 1);
    chk("vecC_ferr", frame_err, 1);
    retire("vecC");

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
